wb_dest_scoreboard: RTL and testbench

Issue-stage scoreboard and destination-select controller for the pipelined RISC core.
- Drives the select of the 5-bit write-back register-address mux, choosing rd (R-type) or rt (I-type).
- Tracks in-flight destination registers and stalls decode on RAW/WAW hazards or when the in-flight limit is reached.
- Sits between decode and the ID/EX register; the write-back stage returns completed destinations.

---
 rtl/wb_dest_scoreboard.sv | 124 ++++++++++++
 tb/tb_wb_dest_scoreboard.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wb_dest_scoreboard.sv
// wb_dest_scoreboard
//   Issue-stage scoreboard and destination-select controller. It sits between
//   decode and the ID/EX register. It resolves the write-back destination
//   (rd for R-type, rt for I-type). It tracks in-flight destination registers
//   and holds decode on RAW/WAW hazards, or when the number of outstanding
//   writers reaches MAX_INFLIGHT. The write-back stage returns completed
//   destinations through wb_valid/wb_addr.
//
// Optional build macro: SB_WB_BYPASS_EN
//   Defined   : a valid same-cycle write-back is masked out of the hazard view.
//               A dependent instruction therefore issues in the write-back
//               cycle. That clear also counts toward relieving the in-flight
//               limit.
//   Undefined : hazard checks see only the registered scoreboard, so a
//               dependent instruction issues one cycle after write-back.
//
// Ports
//   clk, rst       : core clock; synchronous active-high reset
//   id_valid       : decode holds a valid instruction
//   id_rs, id_rt   : source registers (id_rt is also the I-type destination)
//   id_rd          : R-type destination
//   id_reg_dst     : 1 = destination rd, 0 = destination rt
//   id_reg_write   : instruction writes the register file
//   id_uses_rt     : rt is read as a source
//   issue_ready    : ID/EX can accept this cycle
//   wb_valid       : write-back retiring a register write
//   wb_addr        : register being written back
//   dst_sel        : address mux select (1 = rd, 0 = rt)
//   dst_addr       : resolved destination
//   stall          : hold decode/fetch
//   issue          : instruction advances to EX this cycle
//   busy_vec       : registered scoreboard, bit n = register n pending
//   inflight_cnt   : registered count of pending writes
module wb_dest_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_uses_rt,
  input  logic             issue_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  output logic             dst_sel,
  output logic [4:0]       dst_addr,
  output logic             stall,
  output logic             issue,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] inflight_cnt
);

  logic             wr_eff;
  logic             clr_hit;
  logic             set_hit;
  logic [31:0]      clr_mask;
  logic [31:0]      set_mask;
  logic [31:0]      busy_chk;
  logic [CNT_W-1:0] cnt_chk;
  logic             raw;
  logic             waw;
  logic             full;

  assign dst_sel  = id_reg_dst;
  assign dst_addr = id_reg_dst ? id_rd : id_rt;

  // r0 is hardwired zero: writes to it never occupy a scoreboard slot.
  assign wr_eff = id_reg_write & (dst_addr != 5'd0);

  // A write-back only retires if it targets a pending, non-zero register.
  // Stray or stale returns (for example after a reset) are dropped here.
  assign clr_hit  = wb_valid & (wb_addr != 5'd0) & busy_vec[wb_addr];
  assign clr_mask = clr_hit ? (32'd1 << wb_addr) : 32'd0;

`ifdef SB_WB_BYPASS_EN
  // The retiring register reads as free this cycle. The retiring slot is
  // also free, so the limit check sees the post-clear count.
  assign busy_chk = busy_vec & ~clr_mask;
  assign cnt_chk  = inflight_cnt - CNT_W'(clr_hit);
`else
  assign busy_chk = busy_vec;
  assign cnt_chk  = inflight_cnt;
`endif

  always_comb begin
    raw  = 1'b0;
    waw  = 1'b0;
    full = 1'b0;
    if (id_rs != 5'd0 && busy_chk[id_rs])
      raw = 1'b1;
    if (id_uses_rt && id_rt != 5'd0 && busy_chk[id_rt])
      raw = 1'b1;
    if (wr_eff && busy_chk[dst_addr])
      waw = 1'b1;
    if (wr_eff && cnt_chk == CNT_W'(MAX_INFLIGHT))
      full = 1'b1;
  end

  // Stall ignores issue_ready. A frozen pipeline and a hazard are reported
  // separately. Both stall and issue are forced low while reset is held.
  assign stall = ~rst & id_valid & (raw | waw | full);
  assign issue = ~rst & id_valid & ~stall & issue_ready;

  assign set_hit  = issue & wr_eff;
  assign set_mask = set_hit ? (32'd1 << dst_addr) : 32'd0;

  // The clear is applied before the set. This only matters under bypass,
  // where a waiting writer can reclaim its register in the retire cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec     <= 32'd0;
      inflight_cnt <= '0;
    end else begin
      busy_vec     <= (busy_vec & ~clr_mask) | set_mask;
      inflight_cnt <= inflight_cnt + CNT_W'(set_hit) - CNT_W'(clr_hit);
    end
  end

endmodule

// File: tb/tb_wb_dest_scoreboard.sv
module tb_wb_dest_scoreboard;

  localparam int MAXI  = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs, id_rt, id_rd;
  logic             id_reg_dst, id_reg_write, id_uses_rt;
  logic             issue_ready;
  logic             wb_valid;
  logic [4:0]       wb_addr;
  logic             dst_sel;
  logic [4:0]       dst_addr;
  logic             stall, issue;
  logic [31:0]      busy_vec;
  logic [CNT_W-1:0] inflight_cnt;

  always #5 clk = ~clk;

  wb_dest_scoreboard #(.MAX_INFLIGHT(MAXI), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_uses_rt(id_uses_rt), .issue_ready(issue_ready), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .dst_sel(dst_sel), .dst_addr(dst_addr), .stall(stall),
    .issue(issue), .busy_vec(busy_vec), .inflight_cnt(inflight_cnt)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [4:0]  rs, rt, rd;
    logic        rdst, wr, urt, rdy, wbv;
    logic [4:0]  wba;
    logic        e_sel;
    logic [4:0]  e_addr;
    logic        e_stall, e_issue;
    logic [31:0] e_busy;
    int          e_cnt;
  } vec_t;

  vec_t vt[$];
  int   tests  = 0;
  int   errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Inputs only; the expected fields are filled by add().
  function automatic vec_t mk(input logic r, input logic v, input int rs,
                              input int rt, input int rd, input logic rdst,
                              input logic wr, input logic urt, input logic rdy,
                              input logic wbv, input int wba);
    vec_t x;
    x.rst = r; x.vld = v; x.rs = 5'(rs); x.rt = 5'(rt); x.rd = 5'(rd);
    x.rdst = rdst; x.wr = wr; x.urt = urt; x.rdy = rdy; x.wbv = wbv;
    x.wba = 5'(wba);
    x.e_sel = rdst; x.e_addr = rdst ? 5'(rd) : 5'(rt);
    x.e_stall = 1'b0; x.e_issue = 1'b0; x.e_busy = 32'd0; x.e_cnt = 0;
    return x;
  endfunction

  task automatic add(input vec_t x, input logic st, input logic is,
                     input logic [31:0] b, input int c);
    x.e_stall = st; x.e_issue = is; x.e_busy = b; x.e_cnt = c;
    vt.push_back(x);
  endtask

  task automatic drive(input vec_t x);
    rst = x.rst; id_valid = x.vld; id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
    id_reg_dst = x.rdst; id_reg_write = x.wr; id_uses_rt = x.urt;
    issue_ready = x.rdy; wb_valid = x.wbv; wb_addr = x.wba;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
  endtask

  initial begin
    idle();
    rst = 1'b1;

    // Columns: rst vld rs rt rd rdst wr urt rdy wbv wba.
    // Arguments to add(): stall, issue, then busy/cnt after the edge.
    add(mk(1,1, 0, 0, 5,1,1,0,1,0, 0), 0,0, 32'h0, 0);       // reset
    add(mk(0,1, 0, 0, 5,1,1,0,1,0, 0), 0,1, 32'h20, 1);      // R-type rd=5
    add(mk(0,1, 5, 0, 0,1,0,0,1,0, 0), 1,0, 32'h20, 1);      // RAW on rs
`ifdef SB_WB_BYPASS_EN
    add(mk(0,1, 5, 0, 0,1,0,0,1,1, 5), 0,1, 32'h0, 0);       // issues with wb
`else
    add(mk(0,1, 5, 0, 0,1,0,0,1,1, 5), 1,0, 32'h0, 0);       // waits for wb
`endif
    add(mk(0,1, 5, 0, 0,1,0,0,1,0, 0), 0,1, 32'h0, 0);
    add(mk(0,1, 0, 9, 0,0,1,0,1,0, 0), 0,1, 32'h200, 1);     // I-type rt=9
    add(mk(0,1, 0, 9, 0,0,1,0,1,0, 0), 1,0, 32'h200, 1);     // WAW on r9
    add(mk(0,1, 0, 0, 0,1,1,0,1,0, 0), 0,1, 32'h200, 1);     // write to r0
    add(mk(0,0, 0, 0, 0,0,0,0,1,1, 9), 0,0, 32'h0, 0);
    add(mk(0,1, 0, 0, 1,1,1,0,1,0, 0), 0,1, 32'h2, 1);       // fill r1..r4
    add(mk(0,1, 0, 0, 2,1,1,0,1,0, 0), 0,1, 32'h6, 2);
    add(mk(0,1, 0, 0, 3,1,1,0,1,0, 0), 0,1, 32'hE, 3);
    add(mk(0,1, 0, 0, 4,1,1,0,1,0, 0), 0,1, 32'h1E, 4);
    add(mk(0,1, 0, 0, 6,1,1,0,1,0, 0), 1,0, 32'h1E, 4);      // full
`ifdef SB_WB_BYPASS_EN
    add(mk(0,1, 0, 0, 6,1,1,0,1,1, 2), 0,1, 32'h5A, 4);
    add(mk(0,1, 0, 0, 6,1,1,0,1,0, 0), 1,0, 32'h5A, 4);      // now WAW on r6
`else
    add(mk(0,1, 0, 0, 6,1,1,0,1,1, 2), 1,0, 32'h1A, 3);
    add(mk(0,1, 0, 0, 6,1,1,0,1,0, 0), 0,1, 32'h5A, 4);
`endif
    add(mk(0,0, 0, 0, 0,0,0,0,1,1, 1), 0,0, 32'h58, 3);
    add(mk(0,1, 0, 0, 7,1,1,0,1,1, 3), 0,1, 32'hD0, 3);      // set+clear
    add(mk(0,0, 0, 0, 0,0,0,0,1,1,12), 0,0, 32'hD0, 3);      // wb not busy
    add(mk(0,1, 0, 0, 8,1,1,0,0,0, 0), 0,0, 32'hD0, 3);      // not ready
    add(mk(1,1, 4, 0,10,1,1,0,1,0, 0), 0,0, 32'h0, 0);       // mid reset
    add(mk(0,0, 0, 0, 0,0,0,0,1,1, 4), 0,0, 32'h0, 0);       // stale wb
    add(mk(0,1, 0, 0,11,1,1,0,1,0, 0), 0,1, 32'h800, 1);
    add(mk(0,1, 0,11, 0,1,0,1,1,0, 0), 1,0, 32'h800, 1);     // RAW on rt
    add(mk(0,1, 0,11, 0,1,0,0,1,0, 0), 0,1, 32'h800, 1);     // rt not a source

    @(posedge clk); #1;
    foreach (vt[i]) begin
      drive(vt[i]);
      #1;
      chk("dst_sel",  i, 32'(dst_sel),  32'(vt[i].e_sel));
      chk("dst_addr", i, 32'(dst_addr), 32'(vt[i].e_addr));
      chk("stall",    i, 32'(stall),    32'(vt[i].e_stall));
      chk("issue",    i, 32'(issue),    32'(vt[i].e_issue));
      @(posedge clk); #1;
      chk("busy_vec", i, busy_vec,          vt[i].e_busy);
      chk("cnt",      i, 32'(inflight_cnt), 32'(vt[i].e_cnt));
    end

    // Saturation sequence: offer writers to r16..r23 back to back. Only the
    // first MAXI may issue, and the count must never pass the limit.
    rst = 1'b1; @(posedge clk); #1;
    idle();
    for (int k = 16; k < 24; k++) begin
      drive(mk(0,1, 0, 0, k,1,1,0,1,0, 0));
      #1;
      chk("sat_issue", k, 32'(issue), (k < 16 + MAXI) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      chk("sat_cnt_le", k, 32'(inflight_cnt <= CNT_W'(MAXI)), 32'd1);
    end
    chk("sat_busy", 0, busy_vec, 32'h000F_0000);
    idle();
    for (int k = 16; k < 20; k++) begin
      wb_valid = 1'b1; wb_addr = 5'(k);
      @(posedge clk); #1;
    end
    wb_valid = 1'b0;
    chk("drain_busy", 0, busy_vec, 32'h0);
    chk("drain_cnt",  0, 32'(inflight_cnt), 32'h0);

    // A write-back to an empty scoreboard must not underflow the count.
    wb_valid = 1'b1; wb_addr = 5'd16;
    @(posedge clk); #1;
    wb_valid = 1'b0;
    chk("no_underflow", 0, 32'(inflight_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
